// File: rtl/voice_sequencer_if.sv
// voice_sequencer_if: start/ready handshake and per-voice config bus between
// the frame sequencer (master) and the shared voice engine (slave).
interface voice_sequencer_if #(
    parameter int VW     = 2,
    parameter int WAVE_W = 10
);
    logic                     start;
    logic [VW-1:0]            act_voice;
    logic [15:0]              freq_word;
    logic [11:0]              pw_word;
    logic [3:0]               wave_sel;
    logic                     sync;
    logic                     ring_mod;
    logic                     ready;
    logic signed [WAVE_W-1:0] wave;

    modport master (
        output start, act_voice, freq_word, pw_word, wave_sel, sync, ring_mod,
        input  ready, wave
    );
    modport slave (
        input  start, act_voice, freq_word, pw_word, wave_sel, sync, ring_mod,
        output ready, wave
    );
endinterface

// File: rtl/voice_sequencer.sv
// voice_sequencer: steps every voice through the shared engine once per sample
// tick and sums the enabled voices into one signed mix sample.
module voice_sequencer #(
    parameter int NUM_VOICES = 3,
    parameter int WAVE_W     = 10,
    parameter int TIMEOUT    = 15
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           sample_tick_i,
    input  logic [NUM_VOICES-1:0]          voice_en_i,
    input  logic [NUM_VOICES*16-1:0]       freq_word_i,
    input  logic [NUM_VOICES*12-1:0]       pw_word_i,
    input  logic [NUM_VOICES*4-1:0]        wave_sel_i,
    input  logic [NUM_VOICES-1:0]          sync_i,
    input  logic [NUM_VOICES-1:0]          ring_mod_i,
    voice_sequencer_if.master              eng,
    output logic [NUM_VOICES*WAVE_W-1:0]   voice_sample_o,
    output logic signed [WAVE_W+1:0]       mix_o,
    output logic                           sample_valid_o,
    output logic                           busy_o,
    output logic                           overrun_o,
    output logic                           timeout_o
);
    localparam int VW = $clog2(NUM_VOICES);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [1:0] IDLE = 2'd0, START = 2'd1, WAIT = 2'd2, DONE = 2'd3;

    logic [1:0]               state;
    logic [VW-1:0]            v, lv;
    logic [CW-1:0]            cnt;
    logic signed [WAVE_W+1:0] acc, acc_nxt;
    logic                     cap, tmo, fin, last, ld;
    logic [15:0]              fw [NUM_VOICES];
    logic [11:0]              pw [NUM_VOICES];
    logic [3:0]               ws [NUM_VOICES];
    logic [WAVE_W-1:0]        smp [NUM_VOICES];

    for (genvar i = 0; i < NUM_VOICES; i++) begin : g_voice
        assign fw[i] = freq_word_i[i*16 +: 16];
        assign pw[i] = pw_word_i[i*12 +: 12];
        assign ws[i] = wave_sel_i[i*4 +: 4];
        assign voice_sample_o[i*WAVE_W +: WAVE_W] = smp[i];
    end

    // ready on the final WAIT cycle takes priority over the timeout
    assign cap     = state == WAIT && eng.ready;
    assign tmo     = state == WAIT && !eng.ready && cnt == CW'(TIMEOUT - 1);
    assign fin     = cap || tmo;
    assign last    = v == VW'(NUM_VOICES - 1);
    assign ld      = (state == IDLE && sample_tick_i) || (fin && !last);
    assign lv      = state == IDLE ? '0 : v + 1'b1;
    assign acc_nxt = (cap && voice_en_i[v]) ? acc + {{2{eng.wave[WAVE_W-1]}}, eng.wave} : acc;

    assign eng.start      = state == START;
    assign sample_valid_o = state == DONE;
    assign busy_o         = state != IDLE;
    assign overrun_o      = sample_tick_i && busy_o;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state         <= IDLE;
            v             <= '0;
            cnt           <= '0;
            acc           <= '0;
            mix_o         <= '0;
            timeout_o     <= 1'b0;
            eng.act_voice <= '0;
            eng.freq_word <= '0;
            eng.pw_word   <= '0;
            eng.wave_sel  <= '0;
            eng.sync      <= 1'b0;
            eng.ring_mod  <= 1'b0;
            for (int k = 0; k < NUM_VOICES; k++) smp[k] <= '0;
        end else begin
            // config is latched on the edge entering START and held through WAIT
            if (ld) begin
                v             <= lv;
                eng.act_voice <= lv;
                eng.freq_word <= fw[lv];
                eng.pw_word   <= pw[lv];
                eng.wave_sel  <= ws[lv];
                eng.sync      <= sync_i[lv];
                eng.ring_mod  <= ring_mod_i[lv];
            end
            if (state == IDLE && sample_tick_i) begin
                state <= START;
                acc   <= '0;
            end
            if (state == START) begin
                state <= WAIT;
                cnt   <= '0;
            end
            if (state == WAIT) cnt <= cnt + 1'b1;
            if (fin) begin
                smp[v] <= cap ? eng.wave : '0;
                acc    <= acc_nxt;
                state  <= last ? DONE : START;
            end
            if (fin && last) mix_o <= acc_nxt;
            if (tmo) timeout_o <= 1'b1;
            if (state == DONE) state <= IDLE;
        end
    end
endmodule

// File: tb/tb_voice_sequencer.sv
// tb_voice_sequencer: random and directed frames against a per-voice timing
// and mixing reference model, with a behavioural engine responder.
module tb_voice_sequencer;
    localparam int NV = 3, W = 10, TO = 15;

    logic clk = 1'b0, rst = 1'b1, tick = 1'b0;
    logic [NV-1:0] en = '0, sync_in = '0, ring_in = '0;
    logic [NV*16-1:0] fw = '0;
    logic [NV*12-1:0] pw = '0;
    logic [NV*4-1:0] ws = '0;
    logic [NV*W-1:0] vs;
    logic signed [W+1:0] mix;
    logic sv, busy, ovr, tmo;

    voice_sequencer_if eif ();

    voice_sequencer dut (
        .clk_i(clk), .rst_i(rst), .sample_tick_i(tick), .voice_en_i(en),
        .freq_word_i(fw), .pw_word_i(pw), .wave_sel_i(ws), .sync_i(sync_in),
        .ring_mod_i(ring_in), .eng(eif), .voice_sample_o(vs), .mix_o(mix),
        .sample_valid_o(sv), .busy_o(busy), .overrun_o(ovr), .timeout_o(tmo)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int wv [NV];
    int dl [NV];
    int t0;
    bit tmo_exp = 1'b0;
    int checks = 0, errors = 0;

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // engine: ready dl[v] cycles after start with sample wv[v]; dl[v]==0 never answers
    int e_d, e_w;
    initial begin
        eif.ready = 1'b0;
        eif.wave  = '0;
        forever begin
            @(negedge clk);
            if (eif.start && dl[eif.act_voice] > 0) begin
                e_d = dl[eif.act_voice];
                e_w = wv[eif.act_voice];
                repeat (e_d) @(posedge clk);
                #1 eif.ready = 1'b1;
                eif.wave = W'(e_w);
                @(posedge clk);
                #1 eif.ready = 1'b0;
            end
        end
    end

    typedef struct {int c; int v; int f; int p; int w; int s; int r;} sev_t;
    sev_t sq[$];
    int vq[$], mq[$], oq[$];
    sev_t ev;
    always @(negedge clk) begin
        if (eif.start) begin
            ev.c = cyc; ev.v = int'(eif.act_voice); ev.f = int'(eif.freq_word);
            ev.p = int'(eif.pw_word); ev.w = int'(eif.wave_sel);
            ev.s = int'(eif.sync); ev.r = int'(eif.ring_mod);
            sq.push_back(ev);
        end
        if (sv) begin
            vq.push_back(cyc);
            mq.push_back(int'(mix));
        end
        if (ovr) oq.push_back(cyc);
    end

    task automatic randomize_cfg();
        for (int v = 0; v < NV; v++) begin
            fw[v*16 +: 16] = 16'($urandom());
            pw[v*12 +: 12] = 12'($urandom());
            ws[v*4 +: 4]   = 4'($urandom());
            sync_in[v]     = 1'($urandom());
            ring_in[v]     = 1'($urandom());
        end
    endtask

    task automatic check_reset();
        check("rst_start", eif.start, 0);
        check("rst_busy", busy, 0);
        check("rst_valid", sv, 0);
        check("rst_act_voice", eif.act_voice, 0);
        check("rst_freq", eif.freq_word, 0);
        check("rst_mix", mix, 0);
        check("rst_samples", vs, 0);
        check("rst_timeout", tmo, 0);
    endtask

    task automatic issue_tick();
        @(posedge clk);
        #1;
        sq.delete(); vq.delete(); mq.delete(); oq.delete();
        tick = 1'b1;
        t0 = cyc;
    endtask

    task automatic run_frame(input int ovr_off);
        int st [NV];
        int es [NV];
        int t, sum, n;
        issue_tick();
        n = 0;
        while (vq.size() == 0 && n < 120) begin
            @(posedge clk);
            #1;
            n++;
            tick = (ovr_off > 0 && cyc == t0 + ovr_off);
        end
        tick = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        t = t0 + 1;
        sum = 0;
        for (int v = 0; v < NV; v++) begin
            st[v] = t;
            if (dl[v] >= 1 && dl[v] <= TO) begin
                t += dl[v] + 1;
                es[v] = wv[v];
                if (en[v]) sum += wv[v];
            end else begin
                t += TO + 1;
                es[v] = 0;
                tmo_exp = 1'b1;
            end
        end
        check("valid_cnt", vq.size(), 1);
        if (vq.size() > 0) begin
            check("valid_cyc", vq[0] - t0, t - t0);
            check("mix_at_valid", mq[0], sum);
        end
        check("start_cnt", sq.size(), NV);
        for (int v = 0; v < NV && v < sq.size(); v++) begin
            check("start_cyc", sq[v].c - t0, st[v] - t0);
            check("act_voice", sq[v].v, v);
            check("freq", sq[v].f, int'(fw[v*16 +: 16]));
            check("pw", sq[v].p, int'(pw[v*12 +: 12]));
            check("wave_sel", sq[v].w, int'(ws[v*4 +: 4]));
            check("sync", sq[v].s, int'(sync_in[v]));
            check("ring", sq[v].r, int'(ring_in[v]));
        end
        for (int v = 0; v < NV; v++) check("sample", $signed(vs[v*W +: W]), es[v]);
        check("mix_hold", mix, sum);
        check("timeout", tmo, tmo_exp);
        check("busy_after", busy, 0);
        check("overrun_cnt", oq.size(), ovr_off > 0 ? 1 : 0);
        if (ovr_off > 0 && oq.size() > 0) check("overrun_cyc", oq[0] - t0, ovr_off);
    endtask

    task automatic reset_mid(input int off);
        issue_tick();
        while (cyc < t0 + off) begin
            @(posedge clk);
            #1 tick = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        check_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        tmo_exp = 1'b0;
        repeat (25) @(posedge clk);
        #1;
        check("abort_no_valid", vq.size(), 0);
        check("abort_samples", vs, 0);
        check("abort_busy", busy, 0);
    endtask

    task automatic set_voices(input int w0, input int w1, input int w2, input int d0, input int d1, input int d2);
        wv[0] = w0; wv[1] = w1; wv[2] = w2;
        dl[0] = d0; dl[1] = d1; dl[2] = d2;
    endtask

    initial begin
        set_voices(100, -50, 7, 3, 3, 3);
        randomize_cfg();
        en = 3'b111;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);

        run_frame(0);
        en = 3'b010;
        randomize_cfg();
        run_frame(0);
        set_voices(-512, -512, -512, 3, 3, 3);
        en = 3'b111;
        run_frame(0);
        set_voices(200, 99, -300, 3, 0, 3);
        run_frame(0);
        set_voices(100, -50, 7, 3, 3, 3);
        randomize_cfg();
        run_frame(6);
        set_voices(100, -50, 7, 3, 3, 3);
        reset_mid(7);
        set_voices(11, -22, 33, 3, 3, 3);
        run_frame(0);
        set_voices(5, 6, 7, 1, 15, 1);
        run_frame(7);

        for (int f = 0; f < 30; f++) begin
            for (int v = 0; v < NV; v++) begin
                wv[v] = $urandom_range(1023) - 512;
                dl[v] = ($urandom_range(9) == 0) ? 0 : $urandom_range(15, 1);
            end
            en = 3'($urandom());
            randomize_cfg();
            run_frame(($urandom_range(1) == 1) ? $urandom_range(7, 1) : 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
